dac_fmt_stage: RTL and testbench

//  Parametrised DAC output conditioner between the demodulator filter output and the DAC pins.

---
 rtl/dac_fmt_pkg.sv | 34 +++
 rtl/dac_fmt_stage_clk_gen.sv | 38 +++
 rtl/dac_fmt_stage.sv | 172 +++++++++++++++++
 tb/tb_dac_fmt_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_fmt_pkg.sv
// rtl/dac_fmt_pkg.sv - shared types and helpers for the DAC output formatter
package dac_fmt_pkg;

   localparam int MUTE_STATE_W = 2;

   typedef enum logic [MUTE_STATE_W-1:0] {
      ST_PLAY    = 2'd0,
      ST_RAMP_DN = 2'd1,
      ST_MUTED   = 2'd2,
      ST_RAMP_UP = 2'd3
   } mute_state_e;

   // Offset-binary zero code for a w-bit DAC; callers cast to their width.
   function automatic logic [31:0] midscale(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

   // Clamp a wide signed value into the signed range of a w-bit word.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                   input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) begin
         return hi;
      end else if (x < lo) begin
         return lo;
      end else begin
         return x;
      end
   endfunction

endpackage

// File: rtl/dac_fmt_stage_clk_gen.sv
// rtl/dac_fmt_stage_clk_gen.sv - divided DAC clock and once-per-period tick
module dac_clk_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic dac_clk_o,
   output logic tick_o
);

   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             dac_clk_q;

   // Wrapping period counter; the tick marks the last clk of each DAC period.
   always_comb begin
      cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + CNT_W'(1);
   end

   // dac_clk is registered from the next count so it is low for the first half period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         dac_clk_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         dac_clk_q <= (cnt_d >= CNT_HALF);
      end
   end

   assign dac_clk_o = dac_clk_q;
   assign tick_o    = (cnt_q == CNT_TOP);

endmodule

// File: rtl/dac_fmt_stage.sv
// rtl/dac_fmt_stage.sv - hold, offset, gain/saturate, soft mute and format for a DAC
module dac_fmt_stage
   import dac_fmt_pkg::*;
#(
   parameter int IN_W       = 12,
   parameter int DAC_W      = 14,
   parameter int DIV        = 4,
   parameter int ATT_MAX    = 14,
   parameter int RAMP_TICKS = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   input  logic [IN_W-1:0]  offset,
   input  logic [3:0]       shift,
   input  logic             fmt,
   input  logic             mute,
   output logic             dac_clk,
   output logic [DAC_W-1:0] dac_out_data,
   output logic             sat_flag,
   output logic             muted
);

   localparam int SUM_W  = IN_W + 1;
   localparam int WIDE_W = IN_W + 16;
   localparam int ATT_W  = $clog2(ATT_MAX + 1);
   localparam int RC_W   = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam logic [ATT_W-1:0] ATT_TOP = ATT_W'(ATT_MAX);
   localparam logic [RC_W-1:0]  RC_TOP  = RC_W'(RAMP_TICKS - 1);
   localparam logic [DAC_W-1:0] MID     = DAC_W'(midscale(DAC_W));

   logic tick;

   logic signed [IN_W-1:0]   hold_q;
   logic signed [SUM_W-1:0]  sum_q;
   logic signed [DAC_W-1:0]  sc_q;
   logic                     sat_q;
   logic signed [DAC_W-1:0]  a_q;
   logic [DAC_W-1:0]         out_q;

   logic signed [WIDE_W-1:0] wide_d;
   logic signed [DAC_W-1:0]  sc_d;
   logic                     sat_d;
   logic [DAC_W:0]           mag_d;
   logic [DAC_W:0]           mag_sh;
   logic signed [DAC_W-1:0]  a_d;
   logic [DAC_W-1:0]         code_d;

   mute_state_e              state_q;
   logic [ATT_W-1:0]         att_q;
   logic [ATT_W-1:0]         att_inc;
   logic [ATT_W-1:0]         att_dec;
   logic [RC_W-1:0]          rcnt_q;
   logic [RC_W-1:0]          rcnt_inc;
   logic                     step;
   logic                     muted_q;

   dac_clk_gen #(.DIV(DIV)) u_clk_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .dac_clk_o(dac_clk),
      .tick_o   (tick)
   );

   // Gain, clamp, attenuation and output formatting datapath.
   always_comb begin
      wide_d = {{(WIDE_W - SUM_W){sum_q[SUM_W-1]}}, sum_q} <<< shift;
      sc_d   = DAC_W'(saturate(64'(wide_d), DAC_W));
      sat_d  = (saturate(64'(wide_d), DAC_W) != 64'(wide_d));
      // Negative values are attenuated on their magnitude so the ramp rounds toward
      // zero and a fully attenuated negative sample lands on 0 rather than -1.
      mag_d  = -{sc_q[DAC_W-1], sc_q};
      mag_sh = mag_d >> att_q;
      if (sc_q[DAC_W-1]) begin
         a_d = DAC_W'(-mag_sh);
      end else begin
         a_d = sc_q >>> att_q;
      end
      code_d = fmt ? a_q : {~a_q[DAC_W-1], a_q[DAC_W-2:0]};
   end

   // Sample hold, offset add, gain stage, attenuation stage and tick-launched output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         sum_q  <= '0;
         sc_q   <= '0;
         sat_q  <= 1'b0;
         a_q    <= '0;
         out_q  <= MID;
      end else begin
         if (in_valid) begin
            hold_q <= in_data;
         end
         sum_q <= {hold_q[IN_W-1], hold_q} + {offset[IN_W-1], offset};
         sc_q  <= sc_d;
         sat_q <= sat_d;
         a_q   <= (state_q == ST_MUTED) ? '0 : a_d;
         if (tick) begin
            out_q <= code_d;
         end
      end
   end

   // Ramp step strobe and saturating attenuation neighbours.
   always_comb begin
      step     = tick && (rcnt_q == RC_TOP);
      rcnt_inc = (rcnt_q == RC_TOP) ? '0 : rcnt_q + RC_W'(1);
      att_inc  = (att_q == ATT_TOP) ? att_q : att_q + ATT_W'(1);
      att_dec  = (att_q == '0) ? att_q : att_q - ATT_W'(1);
   end

   // Soft-mute FSM: a step lands first, then the mute request decides the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_PLAY;
         att_q   <= '0;
         rcnt_q  <= '0;
         muted_q <= 1'b0;
      end else begin
         if (tick) begin
            rcnt_q <= rcnt_inc;
         end
         case (state_q)
            ST_PLAY: begin
               if (mute) begin
                  state_q <= ST_RAMP_DN;
                  rcnt_q  <= '0;
               end
            end
            ST_RAMP_DN: begin
               if (step) begin
                  att_q <= att_inc;
               end
               if (!mute) begin
                  state_q <= ST_RAMP_UP;
                  rcnt_q  <= '0;
               end else if (step && (att_inc == ATT_TOP)) begin
                  state_q <= ST_MUTED;
                  rcnt_q  <= '0;
                  muted_q <= 1'b1;
               end
            end
            ST_MUTED: begin
               if (!mute) begin
                  state_q <= ST_RAMP_UP;
                  rcnt_q  <= '0;
                  muted_q <= 1'b0;
               end
            end
            default: begin
               if (step) begin
                  att_q <= att_dec;
               end
               if (mute) begin
                  state_q <= ST_RAMP_DN;
                  rcnt_q  <= '0;
               end else if (step && (att_dec == '0)) begin
                  state_q <= ST_PLAY;
                  rcnt_q  <= '0;
               end
            end
         endcase
      end
   end

   assign dac_out_data = out_q;
   assign sat_flag     = sat_q;
   assign muted        = muted_q;

endmodule

// File: tb/tb_dac_fmt_stage.sv
// tb/tb_dac_fmt_stage.sv - directed self-checking bench for dac_fmt_stage
module tb_dac_fmt_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [11:0] in_data = '0;
   logic [11:0] offset = '0;
   logic [3:0]  shift = '0;
   logic        fmt = 1'b0;
   logic        mute = 1'b0;
   logic        dac_clk;
   logic [13:0] dac_out_data;
   logic        sat_flag;
   logic        muted;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        valid;
      logic [11:0] din;
      logic [11:0] off;
      logic [3:0]  sh;
      logic        fm;
      logic [13:0] code;
      logic        sat;
   } vec_t;

   vec_t vecs [14];

   dac_fmt_stage #(
      .IN_W(12), .DAC_W(14), .DIV(4), .ATT_MAX(14), .RAMP_TICKS(2)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .offset      (offset),
      .shift       (shift),
      .fmt         (fmt),
      .mute        (mute),
      .dac_clk     (dac_clk),
      .dac_out_data(dac_out_data),
      .sat_flag    (sat_flag),
      .muted       (muted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      in_data  = v.din;
      offset   = v.off;
      shift    = v.sh;
      fmt      = v.fm;
      in_valid = v.valid;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      int   k;
      int   last_rise;
      int   lat;
      int   falls;
      logic prev;
      logic saw_muted;
      vec_t v;

      vecs[0]  = '{1'b1, 12'h000, 12'h000, 4'd0,  1'b0, 14'h2000, 1'b0};
      vecs[1]  = '{1'b1, 12'h400, 12'h000, 4'd2,  1'b0, 14'h3000, 1'b0};
      vecs[2]  = '{1'b1, 12'h400, 12'h000, 4'd2,  1'b1, 14'h1000, 1'b0};
      vecs[3]  = '{1'b1, 12'h7FF, 12'h000, 4'd3,  1'b1, 14'h1FFF, 1'b1};
      vecs[4]  = '{1'b1, 12'h800, 12'h000, 4'd3,  1'b1, 14'h2000, 1'b1};
      vecs[5]  = '{1'b1, 12'h800, 12'h000, 4'd3,  1'b0, 14'h0000, 1'b1};
      vecs[6]  = '{1'b1, 12'hC00, 12'hC00, 4'd2,  1'b1, 14'h2000, 1'b0};
      vecs[7]  = '{1'b1, 12'h7FF, 12'h7FF, 4'd0,  1'b1, 14'h0FFE, 1'b0};
      vecs[8]  = '{1'b1, 12'h800, 12'h800, 4'd0,  1'b1, 14'h3000, 1'b0};
      vecs[9]  = '{1'b1, 12'h001, 12'h000, 4'd13, 1'b1, 14'h1FFF, 1'b1};
      vecs[10] = '{1'b1, 12'hFFF, 12'h000, 4'd13, 1'b1, 14'h2000, 1'b0};
      vecs[11] = '{1'b1, 12'h001, 12'h000, 4'd15, 1'b0, 14'h3FFF, 1'b1};
      vecs[12] = '{1'b1, 12'hFFF, 12'h000, 4'd15, 1'b0, 14'h0000, 1'b1};
      vecs[13] = '{1'b0, 12'h123, 12'h000, 4'd2,  1'b1, 14'h3FFC, 1'b0};

      // Reset values and divided clock phase
      repeat (3) @(negedge clk);
      check("rst_code", 32'(dac_out_data), 32'h2000);
      check("rst_dac_clk", 32'(dac_clk), 32'd0);
      check("rst_sat", 32'(sat_flag), 32'd0);
      check("rst_muted", 32'(muted), 32'd0);
      rst_n = 1'b1;
      prev = 1'b0;
      last_rise = 0;
      for (k = 1; k <= 12; k++) begin
         @(negedge clk);
         check($sformatf("dac_clk_%0d", k), 32'(dac_clk), 32'((k % 4) >= 2));
         if (!prev && dac_clk) begin
            if (last_rise > 0) check("tick_period", 32'(k - last_rise), 32'd4);
            last_rise = k;
         end
         prev = dac_clk;
      end
      check("idle_code", 32'(dac_out_data), 32'h2000);

      // Table of static vectors
      for (int i = 0; i < 14; i++) begin
         apply(vecs[i]);
         check($sformatf("vec%0d_code", i), 32'(dac_out_data), 32'(vecs[i].code));
         check($sformatf("vec%0d_sat", i), 32'(sat_flag), 32'(vecs[i].sat));
      end

      // Latency from strobe to DAC code, launched right at a falling dac_clk
      v = '{1'b1, 12'h000, 12'h000, 4'd2, 1'b0, 14'h2000, 1'b0};
      apply(v);
      @(negedge clk);
      in_data  = 12'h400;
      in_valid = 1'b1;
      lat = 99;
      for (k = 1; k <= 20; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (dac_out_data == 14'h3000) begin
            lat = k;
            check("launch_on_fall", 32'(dac_clk), 32'd0);
            break;
         end
      end
      check("latency_min", 32'(lat >= 5), 32'd1);
      check("latency_max", 32'(lat <= 8), 32'd1);

      // Back-to-back samples: last one wins
      @(negedge clk);
      fmt = 1'b1;
      shift = 4'd0;
      in_valid = 1'b1;
      in_data = 12'h100;
      @(negedge clk) in_data = 12'h200;
      @(negedge clk) in_data = 12'h300;
      @(negedge clk) in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("last_wins", 32'(dac_out_data), 32'h0300);

      // Mute ramp down with -1000 held
      v = '{1'b1, 12'hC18, 12'h000, 4'd0, 1'b0, 14'h1C18, 1'b0};
      apply(v);
      check("play_code", 32'(dac_out_data), 32'h1C18);
      mute = 1'b1;
      @(negedge clk);
      prev = dac_clk;
      falls = 0;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (prev && !dac_clk) falls++;
         prev = dac_clk;
         if (muted) break;
      end
      check("mute_ticks", 32'(falls), 32'd28);
      check("muted_flag", 32'(muted), 32'd1);
      repeat (8) @(negedge clk);
      check("muted_code", 32'(dac_out_data), 32'h2000);

      // Release: value restored one tick after att returns to 0
      mute = 1'b0;
      @(negedge clk);
      check("unmute_flag", 32'(muted), 32'd0);
      prev = dac_clk;
      falls = 0;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (prev && !dac_clk) falls++;
         prev = dac_clk;
         if (dac_out_data == 14'h1C18) break;
      end
      check("unmute_ticks", 32'(falls), 32'd29);

      // Reverse during ramp down at att=5
      mute = 1'b1;
      @(negedge clk);
      prev = dac_clk;
      falls = 0;
      saw_muted = 1'b0;
      for (k = 0; k < 100 && falls < 10; k++) begin
         @(negedge clk);
         if (prev && !dac_clk) falls++;
         prev = dac_clk;
         saw_muted |= muted;
      end
      check("rev_dn_ticks", 32'(falls), 32'd10);
      mute = 1'b0;
      @(negedge clk);
      prev = dac_clk;
      falls = 0;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (prev && !dac_clk) falls++;
         prev = dac_clk;
         saw_muted |= muted;
         if (dac_out_data == 14'h1C18) break;
      end
      check("rev_up_ticks", 32'(falls), 32'd11);
      check("rev_never_muted", 32'(saw_muted), 32'd0);

      // Asynchronous reset mid-ramp with a clipped sample held
      v = '{1'b1, 12'h7FF, 12'h000, 4'd3, 1'b0, 14'h3FFF, 1'b1};
      apply(v);
      mute = 1'b1;
      repeat (30) @(negedge clk);
      check("pre_rst_sat", 32'(sat_flag), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_code", 32'(dac_out_data), 32'h2000);
      check("async_dac_clk", 32'(dac_clk), 32'd0);
      check("async_sat", 32'(sat_flag), 32'd0);
      check("async_muted", 32'(muted), 32'd0);
      mute = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_code", 32'(dac_out_data), 32'h2000);
      v = '{1'b1, 12'h400, 12'h000, 4'd2, 1'b0, 14'h3000, 1'b0};
      apply(v);
      check("no_ramp_resume", 32'(dac_out_data), 32'h3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
